inst_mem_loader: RTL and testbench

//  Write-side counterpart of the IF fetch path: fills the instruction Ram before execution.

---
 rtl/inst_mem_loader.sv | 124 ++++++++++++
 tb/tb_inst_mem_loader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Instruction RAM loader: packs a little-endian byte stream into 32-bit words and
// writes them to consecutive word addresses from 0, holding the CPU in reset meanwhile.
module inst_mem_loader #(
    parameter int N = 32,
    parameter int G = 10
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start_i,
    input  logic [G-2:0]   length_i,
    input  logic           byte_valid_i,
    input  logic [7:0]     byte_i,
    output logic           byte_ready_o,
    output logic [N-1:0]   mem_address_o,
    output logic [N-1:0]   mem_data_o,
    output logic           mem_EN_o,
    output logic           mem_ByteMode_o,
    output logic           cpu_hold_o,
    output logic           busy_o,
    output logic           done_o,
    output logic [1:0]     dbg_state_o
);

    localparam int LW  = G - 1;
    localparam int CAP = 2 ** (G - 2);
    localparam logic [LW-1:0] CAP_L = LW'(CAP);
    localparam logic [LW-1:0] ONE_L = LW'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   word_cnt_q, word_cnt_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic [31:0]     shift_q, shift_d;

    logic [LW-1:0]   clamped_len;
    logic [LW-1:0]   word_inc;
    logic [4:0]      lane_base;

    // Handshake: a byte moves on a rising edge where byte_valid_i && byte_ready_o;
    // the sender must keep byte_i stable while valid is high and ready is low.
    assign clamped_len    = (length_i > CAP_L) ? CAP_L : length_i;
    assign word_inc       = word_cnt_q + ONE_L;
    assign lane_base      = {byte_cnt_q, 3'b000};
    assign mem_ByteMode_o = 1'b0;
    assign dbg_state_o    = state_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        word_cnt_d    = word_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        shift_d       = shift_q;
        byte_ready_o  = 1'b0;
        mem_address_o = '0;
        mem_data_o    = '0;
        mem_EN_o      = 1'b0;
        cpu_hold_o    = 1'b0;
        busy_o        = 1'b0;
        done_o        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d      = clamped_len;
                    word_cnt_d = '0;
                    byte_cnt_d = '0;
                    shift_d    = '0;
                    state_d    = (clamped_len == '0) ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                byte_ready_o = 1'b1;
                cpu_hold_o   = 1'b1;
                busy_o       = 1'b1;
                if (byte_valid_i) begin
                    shift_d[lane_base +: 8] = byte_i;
                    byte_cnt_d              = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                mem_EN_o      = 1'b1;
                mem_address_o = {{(N-LW-2){1'b0}}, word_cnt_q, 2'b00};
                mem_data_o    = shift_q;
                cpu_hold_o    = 1'b1;
                busy_o        = 1'b1;
                word_cnt_d    = word_inc;
                byte_cnt_d    = '0;
                state_d       = (word_inc == len_q) ? S_DONE : S_RECV;
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized bench for inst_mem_loader: expected RAM writes are queued by the driver
// and popped by an independent monitor; a bench-side RAM image tracks written words.
module tb_inst_mem_loader;

    localparam int N   = 32;
    localparam int G   = 10;
    localparam int CAP = 2 ** (G - 2);

    logic           CLK = 1'b0;
    logic           RST = 1'b0;
    logic           start_i = 1'b0;
    logic [G-2:0]   length_i = '0;
    logic           byte_valid_i = 1'b0;
    logic [7:0]     byte_i = '0;
    logic           byte_ready_o;
    logic [N-1:0]   mem_address_o;
    logic [N-1:0]   mem_data_o;
    logic           mem_EN_o;
    logic           mem_ByteMode_o;
    logic           cpu_hold_o;
    logic           busy_o;
    logic           done_o;
    logic [1:0]     dbg_state_o;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic inject_start = 1'b0;

    logic [63:0] exp_q[$];
    logic [7:0]  stim_bytes[$];
    logic [31:0] ram_model [0:CAP-1];

    inst_mem_loader #(.N(N), .G(G)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .start_i       (start_i),
        .length_i      (length_i),
        .byte_valid_i  (byte_valid_i),
        .byte_i        (byte_i),
        .byte_ready_o  (byte_ready_o),
        .mem_address_o (mem_address_o),
        .mem_data_o    (mem_data_o),
        .mem_EN_o      (mem_EN_o),
        .mem_ByteMode_o(mem_ByteMode_o),
        .cpu_hold_o    (cpu_hold_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .dbg_state_o   (dbg_state_o)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshake counter, sampled before the DUT updates on this edge
    always @(posedge CLK) begin
        if (RST && byte_valid_i && byte_ready_o) hs_cnt++;
    end

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (RST) begin
            if (done_o) done_cnt++;
            if (mem_EN_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                             mem_address_o, mem_data_o);
                end else begin
                    logic [63:0] e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(mem_address_o), {32'h0, e[63:32]});
                    chk("wr_data", 64'(mem_data_o), {32'h0, e[31:0]});
                    chk("wr_bytemode", 64'(mem_ByteMode_o), 64'h0);
                    chk("wr_ready_low", 64'(byte_ready_o), 64'h0);
                    chk("wr_hold", 64'(cpu_hold_o), 64'h1);
                end
                ram_model[mem_address_o[G-1:2]] = mem_data_o;
            end
        end
    end

    task automatic fill_random(input int nwords);
        stim_bytes.delete();
        for (int i = 0; i < nwords * 4; i++) stim_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    function automatic logic [31:0] word_of(input int w);
        return {stim_bytes[4*w+3], stim_bytes[4*w+2], stim_bytes[4*w+1], stim_bytes[4*w]};
    endfunction

    // mode 0: always valid, 1: valid every other cycle, 2: random valid.
    // abort_at >= 0 stops feeding after that many accepted bytes and leaves the load running.
    task automatic run_load(input int len, input int mode, input int abort_at);
        int eff, nwords, nbytes, idx, cyc, budget;
        logic want, pending;
        eff    = (len > CAP) ? CAP : len;
        nwords = (abort_at < 0) ? eff : abort_at / 4;
        nbytes = (abort_at < 0) ? eff * 4 : abort_at;
        for (int w = 0; w < nwords; w++) exp_q.push_back({32'(w * 4), word_of(w)});

        @(negedge CLK);
        start_i  = 1'b1;
        length_i = (G-1)'(len);
        if (nbytes > 0) begin
            byte_valid_i = 1'b1;
            byte_i       = stim_bytes[0];
        end
        @(negedge CLK);
        start_i = 1'b0;
        if (eff == 0) begin
            byte_valid_i = 1'b0;
            chk("len0_done", 64'(done_o), 64'h1);
            chk("len0_hold", 64'(cpu_hold_o), 64'h0);
            exp_done++;
            @(negedge CLK);
            chk("len0_done_clear", 64'(done_o), 64'h0);
            return;
        end
        chk("hold_after_start", 64'(cpu_hold_o), 64'h1);
        chk("busy_after_start", 64'(busy_o), 64'h1);

        idx = 0;
        cyc = 0;
        pending = 1'b1;
        budget = nbytes * 8 + 50;
        while (idx < nbytes && cyc < budget) begin
            if (pending) want = 1'b1;
            else if (mode == 0) want = 1'b1;
            else if (mode == 1) want = (cyc % 2 == 0);
            else want = 1'($urandom_range(0, 1));
            if (want) begin
                byte_valid_i = 1'b1;
                byte_i       = stim_bytes[idx];
                if (byte_ready_o) begin
                    idx++;
                    pending = 1'b0;
                end else begin
                    pending = 1'b1;
                end
            end else begin
                byte_valid_i = 1'b0;
                byte_i       = 8'($urandom_range(0, 255));
            end
            start_i  = inject_start && (cyc == 3);
            length_i = (G-1)'($urandom_range(0, 7));
            @(negedge CLK);
            cyc++;
        end
        byte_valid_i = 1'b0;
        start_i      = 1'b0;
        if (idx < nbytes) begin
            checks++;
            failures++;
            $display("FAIL byte_feed_timeout: accepted %0d of %0d bytes", idx, nbytes);
            return;
        end
        if (abort_at >= 0) return;

        chk("write_latency_en", 64'(mem_EN_o), 64'h1);
        @(negedge CLK);
        chk("done_pulse", 64'(done_o), 64'h1);
        chk("done_hold_low", 64'(cpu_hold_o), 64'h0);
        chk("done_busy_low", 64'(busy_o), 64'h0);
        exp_done++;
        @(negedge CLK);
        chk("done_clear", 64'(done_o), 64'h0);
        chk("idle_ready_low", 64'(byte_ready_o), 64'h0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(byte_ready_o), 64'h0);
        chk({tag, "_en"}, 64'(mem_EN_o), 64'h0);
        chk({tag, "_hold"}, 64'(cpu_hold_o), 64'h0);
        chk({tag, "_busy"}, 64'(busy_o), 64'h0);
        chk({tag, "_done"}, 64'(done_o), 64'h0);
        chk({tag, "_addr"}, 64'(mem_address_o), 64'h0);
        chk({tag, "_data"}, 64'(mem_data_o), 64'h0);
    endtask

    initial begin : main
        int hs_start;
        logic [31:0] w0;
        logic [31:0] saved[4];

        for (int i = 0; i < CAP; i++) ram_model[i] = '0;

        // Reset
        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST = 1'b1;
        @(negedge CLK);
        check_all_zero("post_reset");

        // Single word, known bytes
        stim_bytes = '{8'h13, 8'h00, 8'hA0, 8'hE3};
        run_load(1, 0, -1);
        chk("single_word_ram", 64'(ram_model[0]), 64'h0000_0000_E3A0_0013);

        // Three words, valid every other cycle, stray start mid-load
        fill_random(3);
        hs_start = hs_cnt;
        inject_start = 1'b1;
        run_load(3, 1, -1);
        inject_start = 1'b0;
        chk("three_word_handshakes", 64'(hs_cnt - hs_start), 64'd12);

        // Zero length, then over-length clamped to capacity
        run_load(0, 0, -1);
        fill_random(CAP);
        run_load(CAP + 5, 0, -1);
        chk("clamp_last_word", 64'(ram_model[CAP-1]), 64'(word_of(CAP - 1)));

        // Abort after two bytes of word 1
        fill_random(3);
        w0 = word_of(0);
        run_load(3, 2, 6);
        #2 RST = 1'b0;
        #1 check_all_zero("abort");
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        chk("abort_idle_ready", 64'(byte_ready_o), 64'h0);
        chk("abort_no_pending", 64'(exp_q.size()), 64'h0);
        chk("abort_word0_kept", 64'(ram_model[0]), 64'(w0));
        fill_random(2);
        run_load(2, 2, -1);

        // Four-instruction image, then hold released for fetch
        fill_random(4);
        for (int i = 0; i < 4; i++) saved[i] = word_of(i);
        run_load(4, 2, -1);
        chk("image_hold_released", 64'(cpu_hold_o), 64'h0);
        for (int i = 0; i < 4; i++) chk("image_word", 64'(ram_model[i]), 64'(saved[i]));

        // Random short loads
        repeat (4) begin
            int l;
            l = $urandom_range(1, 6);
            fill_random(l);
            run_load(l, 2, -1);
        end

        repeat (2) @(negedge CLK);
        chk("final_queue_empty", 64'(exp_q.size()), 64'h0);
        chk("final_done_count", 64'(done_cnt), 64'(exp_done));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
